bitmap_write_sequencer: RTL and testbench
=========================================

// Module: bitmap_write_sequencer
// PURPOSE
//  Sequences the write port of the 128x96 mono bitmap RAM (1536 bytes) from the SPI slave byte stream.
//  DC=1 bytes are pixel data, written at an auto-incrementing pointer; DC=0 bytes are commands (set address, fill, clear status).
//  Owns the RAM write port and arbitrates it between SPI data and an internal fill engine.
//  Sits between SlaveSPI/Synchronizer and PseudoDualPortRAM; the VGA read side is untouched.
// PARAMETERS
//  ADDRESS_WIDTH  11    width of RAM address / write pointer
//  MEMORY_DEPTH   1536  bytes in bitmap RAM; pointer wraps at MEMORY_DEPTH-1 -> 0
// PORTS
//  Clock            in   1   system clock (25 MHz); single clock domain
//  Reset            in   1   asynchronous, active-low reset
//  Byte_i           in   8   byte from SPI slave, valid when ByteValid_i=1
//  ByteValid_i      in   1   1-cycle strobe per received byte (TransactionDone)
//  DC_i             in   1   synchronized Data/Command: 1=data, 0=command
//  TransmissionStart_i in 1  1-cycle strobe on CS falling edge
//  WriteEnable_o    out  1   RAM write enable
//  WriteAddress_o   out  ADDRESS_WIDTH  RAM write address
//  WriteData_o      out  8   RAM write data
//  Busy_o           out  1   1 while fill engine runs
//  Error_o          out  1   sticky error flag
// BEHAVIOUR
//  Reset: all outputs 0; pointer=0; state IDLE.
//  All outputs registered: a data byte accepted on cycle N gives WriteEnable_o=1 on N+1 for exactly one cycle, at old pointer; pointer then +1.
//  States: IDLE, ADDR_HI, ADDR_LO, FILL_PAT, FILLING.
//  IDLE, DC=1 byte: write Byte_i at pointer; pointer = (pointer==MEMORY_DEPTH-1) ? 0 : pointer+1.
//  IDLE, DC=0 byte: 0x00 NOP; 0x01 -> ADDR_HI; 0x02 -> FILL_PAT; 0x03 clear Error_o; other codes: ignored, Error_o<=1.
//  ADDR_HI: next byte (any DC) latched as addr[15:8] -> ADDR_LO. ADDR_LO: next byte gives addr[7:0] -> IDLE;
//   addr < MEMORY_DEPTH loads pointer, else pointer unchanged and Error_o<=1.
//  FILL_PAT: next byte is pattern -> FILLING, Busy_o=1 from next cycle.
//  FILLING: writes pattern to addresses 0..MEMORY_DEPTH-1, one per cycle (MEMORY_DEPTH cycles of WriteEnable_o);
//   after last write: pointer=0, Busy_o=0, -> IDLE.
//  Any byte arriving during FILLING is dropped and sets Error_o; fill is not disturbed.
//  TransmissionStart_i: aborts ADDR_HI/ADDR_LO/FILL_PAT to IDLE (partial command discarded); ignored in FILLING.
//  Simultaneous TransmissionStart_i and ByteValid_i: start effect applied first, byte then decoded from IDLE.
//  Error_o set and 0x03 clear in same cycle: set wins.
//  Reset asserted mid-fill: fill aborts immediately; RAM contents partially written (not restored).
// CONFIGURATION
//  CS_POINTER_RESET_EN defined: TransmissionStart_i (outside FILLING) also sets pointer=0, so each CS frame
//   of data starts at address 0 (legacy full-frame upload behaviour).
//  Not defined: pointer persists across CS frames; only 0x01 command, wrap or fill end changes it.
// TESTING
//  1) Reset, DC=1 bytes 0xAA,0x55,0xF0 -> writes (0,0xAA),(1,0x55),(2,0xF0), each 1 cycle after strobe.
//  2) DC=0 0x01,0x05,0xFF then DC=1 0x11,0x22 -> writes (1535,0x11),(0,0x22): wrap verified.
//  3) DC=0 0x02,0x3C -> Busy_o=1 for 1536 cycles, 1536 writes of 0x3C addr 0..1535, then Busy_o=0, pointer=0.
//  4) During fill send DC=1 0x77 -> no extra write, Error_o=1; then DC=0 0x03 -> Error_o=0.
//  5) DC=0 0x01,0x06,0x00 (1536) -> pointer unchanged, Error_o=1; DC=0 0x01 then TransmissionStart -> next DC=1 byte written at pointer, no addr load.
//  6) Write 10 bytes, new CS frame, write 0x99 -> with CS_POINTER_RESET_EN at addr 0; without at addr 10.

Source files
------------

// File: rtl/bitmap_write_sequencer.sv
// Write-port sequencer for the 128x96 mono bitmap RAM: SPI data/command decode plus fill engine.
// Optional CS_POINTER_RESET_EN: each CS frame restarts the write pointer at address 0.
module bitmap_write_sequencer #(
    parameter int unsigned ADDRESS_WIDTH = 11,
    parameter int unsigned MEMORY_DEPTH  = 1536
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [7:0]               Byte_i,
    input  logic                     ByteValid_i,
    input  logic                     DC_i,
    input  logic                     TransmissionStart_i,
    output logic                     WriteEnable_o,
    output logic [ADDRESS_WIDTH-1:0] WriteAddress_o,
    output logic [7:0]               WriteData_o,
    output logic                     Busy_o,
    output logic                     Error_o
);

    typedef enum logic [2:0] {StIdle, StAddrHi, StAddrLo, StFillPat, StFilling} state_e;

    localparam logic [ADDRESS_WIDTH-1:0] LastAddr = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] AddrOne  = ADDRESS_WIDTH'(1);

    state_e                   state_q, state_d, state_eff;
    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d, ptr_base;
    logic [7:0]               addr_hi_q, addr_hi_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]               wdata_q, wdata_d;
    logic                     busy_q, busy_d;
    logic                     err_q, err_d;
    logic                     err_set, err_clr;
    logic                     start_abort;
    logic [15:0]              load_addr;

    // A CS start outside a fill drops any partial command before the same-cycle byte is decoded.
    always_comb begin
        start_abort = TransmissionStart_i && (state_q != StFilling);
        state_eff   = start_abort ? StIdle : state_q;
`ifdef CS_POINTER_RESET_EN
        ptr_base    = start_abort ? '0 : ptr_q;
`else
        ptr_base    = ptr_q;
`endif
        load_addr   = {addr_hi_q, Byte_i};
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            addr_hi_q <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            addr_hi_q <= addr_hi_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_eff;
        unique case (state_eff)
            StIdle: begin
                if (ByteValid_i && !DC_i) begin
                    if (Byte_i == 8'h01)      state_d = StAddrHi;
                    else if (Byte_i == 8'h02) state_d = StFillPat;
                end
            end
            StAddrHi:  if (ByteValid_i) state_d = StAddrLo;
            StAddrLo:  if (ByteValid_i) state_d = StIdle;
            StFillPat: if (ByteValid_i) state_d = StFilling;
            StFilling: if (waddr_q == LastAddr) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // During a fill the write address register doubles as the fill counter.
    always_comb begin
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        busy_d    = busy_q;
        ptr_d     = ptr_base;
        addr_hi_d = addr_hi_q;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        unique case (state_eff)
            StIdle: begin
                if (ByteValid_i) begin
                    if (DC_i) begin
                        we_d    = 1'b1;
                        waddr_d = ptr_base;
                        wdata_d = Byte_i;
                        ptr_d   = (ptr_base == LastAddr) ? '0 : ptr_base + AddrOne;
                    end else begin
                        unique case (Byte_i)
                            8'h00, 8'h01, 8'h02: ;
                            8'h03:               err_clr = 1'b1;
                            default:             err_set = 1'b1;
                        endcase
                    end
                end
            end
            StAddrHi: if (ByteValid_i) addr_hi_d = Byte_i;
            StAddrLo: begin
                if (ByteValid_i) begin
                    if (load_addr < 16'(MEMORY_DEPTH)) ptr_d = load_addr[ADDRESS_WIDTH-1:0];
                    else                               err_set = 1'b1;
                end
            end
            StFillPat: begin
                if (ByteValid_i) begin
                    we_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = Byte_i;
                    busy_d  = 1'b1;
                end
            end
            StFilling: begin
                if (ByteValid_i) err_set = 1'b1;
                if (waddr_q == LastAddr) begin
                    busy_d = 1'b0;
                    ptr_d  = '0;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = waddr_q + AddrOne;
                end
            end
            default: ;
        endcase
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    assign WriteEnable_o  = we_q;
    assign WriteAddress_o = waddr_q;
    assign WriteData_o    = wdata_q;
    assign Busy_o         = busy_q;
    assign Error_o        = err_q;

endmodule

// File: tb/tb_bitmap_write_sequencer.sv
// Directed bench for bitmap_write_sequencer: data writes, address load/wrap, fill, errors, CS framing.
module tb_bitmap_write_sequencer;

    logic        Clock;
    logic        Reset;
    logic [7:0]  Byte_i;
    logic        ByteValid_i;
    logic        DC_i;
    logic        TransmissionStart_i;
    logic        WriteEnable_o;
    logic [10:0] WriteAddress_o;
    logic [7:0]  WriteData_o;
    logic        Busy_o;
    logic        Error_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int we_count     = 0;

`ifdef CS_POINTER_RESET_EN
    localparam bit CsReset = 1'b1;
`else
    localparam bit CsReset = 1'b0;
`endif

    bitmap_write_sequencer #(
        .ADDRESS_WIDTH(11),
        .MEMORY_DEPTH (1536)
    ) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .Byte_i             (Byte_i),
        .ByteValid_i        (ByteValid_i),
        .DC_i               (DC_i),
        .TransmissionStart_i(TransmissionStart_i),
        .WriteEnable_o      (WriteEnable_o),
        .WriteAddress_o     (WriteAddress_o),
        .WriteData_o        (WriteData_o),
        .Busy_o             (Busy_o),
        .Error_o            (Error_o)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        #3;
        if (WriteEnable_o === 1'b1) we_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte strobe for one cycle; returns on the negedge after the accepting posedge.
    task automatic send(input logic dc, input logic [7:0] b, input logic st);
        @(negedge Clock);
        DC_i                = dc;
        Byte_i              = b;
        ByteValid_i         = 1'b1;
        TransmissionStart_i = st;
        @(negedge Clock);
        ByteValid_i         = 1'b0;
        TransmissionStart_i = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge Clock);
        TransmissionStart_i = 1'b1;
        @(negedge Clock);
        TransmissionStart_i = 1'b0;
    endtask

    task automatic write_chk(input string tag, input logic [7:0] b, input logic [10:0] addr);
        send(1'b1, b, 1'b0);
        check({tag, " we"}, 32'(WriteEnable_o), 32'd1);
        check({tag, " addr"}, 32'(WriteAddress_o), 32'(addr));
        check({tag, " data"}, 32'(WriteData_o), 32'(b));
        @(negedge Clock);
        check({tag, " we one cycle"}, 32'(WriteEnable_o), 32'd0);
    endtask

    task automatic cmd(input string tag, input logic [7:0] b);
        send(1'b0, b, 1'b0);
        check({tag, " no write"}, 32'(WriteEnable_o), 32'd0);
    endtask

    initial begin
        int good;
        int n;
        int c0;

        Reset               = 1'b0;
        Byte_i              = 8'h00;
        ByteValid_i         = 1'b0;
        DC_i                = 1'b0;
        TransmissionStart_i = 1'b0;
        repeat (3) @(negedge Clock);
        check("reset we", 32'(WriteEnable_o), 32'd0);
        check("reset addr", 32'(WriteAddress_o), 32'd0);
        check("reset data", 32'(WriteData_o), 32'd0);
        check("reset busy", 32'(Busy_o), 32'd0);
        check("reset err", 32'(Error_o), 32'd0);
        Reset = 1'b1;

        // Sequential data writes from pointer 0.
        write_chk("w0", 8'hAA, 11'd0);
        write_chk("w1", 8'h55, 11'd1);
        write_chk("w2", 8'hF0, 11'd2);

        // Address load to the last location, then wrap.
        cmd("set addr", 8'h01);
        cmd("addr hi", 8'h05);
        cmd("addr lo", 8'hFF);
        check("addr load err", 32'(Error_o), 32'd0);
        write_chk("w last", 8'h11, 11'd1535);
        write_chk("w wrap", 8'h22, 11'd0);

        // Full fill with 0x3C, checked cycle by cycle.
        cmd("fill", 8'h02);
        send(1'b0, 8'h3C, 1'b0);
        good = 0;
        for (int i = 0; i < 1536; i++) begin
            if (WriteEnable_o === 1'b1 && Busy_o === 1'b1 && WriteAddress_o === 11'(i)
                && WriteData_o === 8'h3C) good++;
            @(negedge Clock);
        end
        check("fill1 writes", 32'(good), 32'd1536);
        check("fill1 busy end", 32'(Busy_o), 32'd0);
        check("fill1 we end", 32'(WriteEnable_o), 32'd0);
        write_chk("w after fill", 8'h44, 11'd0);

        // Second fill with a byte dropped mid-fill.
        c0 = we_count;
        cmd("fill2", 8'h02);
        send(1'b0, 8'h5A, 1'b0);
        repeat (10) @(negedge Clock);
        send(1'b1, 8'h77, 1'b0);
        check("drop err", 32'(Error_o), 32'd1);
        check("drop busy", 32'(Busy_o), 32'd1);
        check("drop data", 32'(WriteData_o), 32'h5A);
        n = 0;
        while (Busy_o === 1'b1 && n < 2000) begin
            @(negedge Clock);
            n++;
        end
        check("fill2 ends in bound", 32'(n < 2000), 32'd1);
        check("fill2 write count", 32'(we_count - c0), 32'd1536);
        check("err sticky", 32'(Error_o), 32'd1);
        cmd("clear", 8'h03);
        check("err cleared", 32'(Error_o), 32'd0);

        // Out-of-range address, invalid code, aborted and simultaneous CS starts.
        write_chk("w p0", 8'h10, 11'd0);
        cmd("bad set", 8'h01);
        cmd("bad hi", 8'h06);
        cmd("bad lo", 8'h00);
        check("bad addr err", 32'(Error_o), 32'd1);
        write_chk("w unchanged", 8'h20, 11'd1);
        cmd("clear2", 8'h03);
        check("err cleared2", 32'(Error_o), 32'd0);
        cmd("bad code", 8'h07);
        check("bad code err", 32'(Error_o), 32'd1);
        cmd("clear3", 8'h03);
        cmd("abort set", 8'h01);
        pulse_start();
        write_chk("w after abort", 8'h30, CsReset ? 11'd0 : 11'd2);
        check("abort no err", 32'(Error_o), 32'd0);
        cmd("abort set2", 8'h01);
        send(1'b1, 8'h31, 1'b1);
        check("sim start we", 32'(WriteEnable_o), 32'd1);
        check("sim start addr", 32'(WriteAddress_o), CsReset ? 32'd0 : 32'd3);
        check("sim start data", 32'(WriteData_o), 32'h31);

        // CS framing: 10 bytes, new frame, one more byte.
        cmd("frame set", 8'h01);
        cmd("frame hi", 8'h00);
        cmd("frame lo", 8'h00);
        pulse_start();
        for (int i = 0; i < 10; i++) send(1'b1, 8'(i), 1'b0);
        pulse_start();
        write_chk("w new frame", 8'h99, CsReset ? 11'd0 : 11'd10);

        // Fill-pattern command aborted by CS start.
        cmd("fill abort", 8'h02);
        pulse_start();
        write_chk("w fill aborted", 8'h55, CsReset ? 11'd0 : 11'd11);
        check("fill aborted busy", 32'(Busy_o), 32'd0);

        // Reset in the middle of a fill.
        cmd("fill3", 8'h02);
        send(1'b0, 8'hEE, 1'b0);
        repeat (5) @(negedge Clock);
        check("fill3 busy", 32'(Busy_o), 32'd1);
        Reset = 1'b0;
        #1;
        check("midfill reset busy", 32'(Busy_o), 32'd0);
        check("midfill reset we", 32'(WriteEnable_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
